// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/mret redirect sequencer for the single-cycle RV32I core.
// CSR reads are combinational and always return the pre-write value. Writes, trap
// captures and counter updates all commit on the next rising edge of the clock.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  csr_rs1,
    input  logic [31:0] csr_wdata,
    input  logic        instr_retire,
    input  logic [31:0] pc,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t      state_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        run, take_trap, take_mret;
    logic        f3_valid, is_write, read_only, mapped, csr_we;
    logic [31:0] src, old_val, new_val, mstatus_val;

    // Only the RUN state accepts events; the REDIRECT cycle is the flushed slot.
    assign run       = (state_q == RUN);
    assign take_trap = run & trap_req;
    assign take_mret = run & mret & ~trap_req;

    assign src         = csr_funct3[2] ? {27'b0, csr_rs1} : csr_wdata;
    assign f3_valid    = (csr_funct3[1:0] != 2'b00);
    assign is_write    = (csr_funct3[1:0] == 2'b01) | (csr_rs1 != 5'd0);
    assign read_only   = (csr_addr[11:10] == 2'b11);
    assign mstatus_val = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};

    // Address decode and read mux; counters read zero when they are compiled out.
    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (csr_addr)
            12'h300: old_val = mstatus_val;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'hB00, 12'hC00: old_val = HAS_COUNTERS ? mcycle_q[31:0]   : 32'h0;
            12'hB80, 12'hC80: old_val = HAS_COUNTERS ? mcycle_q[63:32]  : 32'h0;
            12'hB02, 12'hC02: old_val = HAS_COUNTERS ? minstret_q[31:0]  : 32'h0;
            12'hB82, 12'hC82: old_val = HAS_COUNTERS ? minstret_q[63:32] : 32'h0;
            default: mapped = 1'b0;
        endcase
    end

    assign illegal   = csr_en & (~mapped | ~f3_valid | (is_write & read_only));
    assign csr_rdata = illegal ? 32'h0 : old_val;

    // Read-modify-write result for the three CSR operation classes.
    always_comb begin
        case (csr_funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    // A trap or mret in the same cycle wins over the CSR write, which is dropped.
    assign csr_we = csr_en & ~illegal & is_write & run & ~trap_req & ~mret;

    // Next-state for the CSR storage: counters tick, then CSR writes, then trap/mret updates.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'b0, instr_retire};
        if (csr_we) begin
            case (csr_addr)
                12'h300: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                12'h305: mtvec_d    = new_val & ~32'h3;
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = new_val & ~32'h3;
                12'h342: mcause_d   = new_val;
                12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
                12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], new_val};
                12'hB82: minstret_d = {new_val, minstret_q[31:0]};
                default: ;
            endcase
        end
        if (take_trap) begin
            mepc_d   = pc & ~32'h3;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (take_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (!HAS_COUNTERS) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    // CSR storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Redirect sequencer: a trap or mret raises a one-cycle registered redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (state_q == RUN) begin
            if (trap_req) begin
                state_q          <= REDIRECT;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= mtvec_q;
            end else if (mret) begin
                state_q          <= REDIRECT;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= mepc_q;
            end else begin
                redirect_valid_q <= 1'b0;
            end
        end else begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
